// File: rtl/shared_tlb_pkg.sv
// Types and constants shared by the second-level TLB and its tag comparator.
// Sv39 layout: 39-bit virtual addresses, 27-bit VPN, 4K/2M/1G pages.
package shared_tlb_pkg;

    localparam int unsigned VLEN     = 39;
    localparam int unsigned ASID_LEN = 1;
    localparam int unsigned VPN_W    = 27;

    typedef struct packed {
        logic [9:0]  reserved;
        logic [43:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic                valid;
        logic                is_2M;
        logic                is_1G;
        logic [VPN_W-1:0]    vpn;
        logic [ASID_LEN-1:0] asid;
        pte_t                content;
    } tlb_update_t;

    typedef struct packed {
        logic                valid;
        logic                is_1G;
        logic                is_2M;
        logic [VPN_W-1:0]    vpn;
        logic [ASID_LEN-1:0] asid;
        pte_t                content;
    } shared_tlb_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOOKUP   = 2'd1,
        WAIT_PTW = 2'd2
    } state_e;

endpackage

// File: rtl/shared_tlb_match.sv
// Combinational tag compare of one shared-TLB entry against a VPN/ASID pair.
// Superpage entries only compare the VPN bits above their page offset.
module shared_tlb_match
    import shared_tlb_pkg::*;
(
    input  shared_tlb_entry_t   entry_i,
    input  logic [VPN_W-1:0]    vpn_i,
    input  logic [ASID_LEN-1:0] asid_i,
    output logic                hit_o
);

    logic asid_ok;
    logic vpn_ok;

    assign asid_ok = entry_i.content.g || (entry_i.asid == asid_i);

    always_comb begin
        if (entry_i.is_1G) begin
            vpn_ok = (entry_i.vpn[26:18] == vpn_i[26:18]);
        end else if (entry_i.is_2M) begin
            vpn_ok = (entry_i.vpn[26:9] == vpn_i[26:9]);
        end else begin
            vpn_ok = (entry_i.vpn == vpn_i);
        end
    end

    assign hit_o = entry_i.valid && asid_ok && vpn_ok;

endmodule

// File: rtl/shared_tlb.sv
// Fully associative second-level TLB: serves ITLB/DTLB misses from its own
// entries, otherwise waits for the PTW fill, stores it and forwards it.
module shared_tlb
    import shared_tlb_pkg::*;
#(
    parameter int unsigned ASID_WIDTH       = ASID_LEN,
    parameter int unsigned SHARED_TLB_DEPTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  flush_tlb_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    input  logic                  itlb_access_i,
    input  logic                  itlb_hit_i,
    input  logic [VLEN-1:0]       itlb_vaddr_i,
    input  logic                  dtlb_access_i,
    input  logic                  dtlb_hit_i,
    input  logic [VLEN-1:0]       dtlb_vaddr_i,
    output tlb_update_t           itlb_update_o,
    output tlb_update_t           dtlb_update_o,
    output logic                  itlb_miss_o,
    output logic                  dtlb_miss_o,
    output logic                  shared_tlb_access_o,
    output logic                  shared_tlb_hit_o,
    output logic [VLEN-1:0]       shared_tlb_vaddr_o,
    output logic                  itlb_req_o,
    input  tlb_update_t           ptw_update_i,
    input  logic                  ptw_active_i
);

    localparam int unsigned IDX_W = $clog2(SHARED_TLB_DEPTH);

    state_e                state_q, state_d;
    logic [VLEN-1:0]       vaddr_q, vaddr_d;
    logic                  is_instr_q, is_instr_d;
    logic                  flushed_q, flushed_d;
    logic [ASID_LEN-1:0]   asid_q, asid_d;
    logic [IDX_W-1:0]      repl_q, repl_d;
    shared_tlb_entry_t     entries_q [SHARED_TLB_DEPTH];
    shared_tlb_entry_t     entries_d [SHARED_TLB_DEPTH];

    logic [SHARED_TLB_DEPTH-1:0] hit_vec, valid_vec;
    logic [IDX_W-1:0]      hit_idx, free_idx, wr_idx;
    logic                  any_hit, any_free;
    logic                  itlb_req, dtlb_req, ptw_wr;
    tlb_update_t           lookup_upd, upd;

    for (genvar gi = 0; gi < SHARED_TLB_DEPTH; gi++) begin : g_match
        shared_tlb_match u_match (
            .entry_i (entries_q[gi]),
            .vpn_i   (vaddr_q[38:12]),
            .asid_i  (asid_q),
            .hit_o   (hit_vec[gi])
        );
        assign valid_vec[gi] = entries_q[gi].valid;
    end

    // Lowest-index hit and lowest-index free slot.
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = SHARED_TLB_DEPTH - 1; i >= 0; i--) begin
            if (hit_vec[i])    hit_idx  = IDX_W'(i);
            if (!valid_vec[i]) free_idx = IDX_W'(i);
        end
    end

    assign any_hit  = |hit_vec;
    assign any_free = ~&valid_vec;
    assign itlb_req = itlb_access_i && !itlb_hit_i && !flush_i;
    assign dtlb_req = dtlb_access_i && !dtlb_hit_i && !flush_i;
    assign ptw_wr   = (state_q == WAIT_PTW) && ptw_update_i.valid;
    assign wr_idx   = any_free ? free_idx : repl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            vaddr_q    <= '0;
            is_instr_q <= 1'b0;
            flushed_q  <= 1'b0;
            asid_q     <= '0;
            repl_q     <= '0;
            for (int i = 0; i < SHARED_TLB_DEPTH; i++) entries_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            vaddr_q    <= vaddr_d;
            is_instr_q <= is_instr_d;
            flushed_q  <= flushed_d;
            asid_q     <= asid_d;
            repl_q     <= repl_d;
            entries_q  <= entries_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vaddr_d    = vaddr_q;
        is_instr_d = is_instr_q;
        flushed_d  = flushed_q;
        asid_d     = asid_q;
        case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if (itlb_req || dtlb_req) begin
                    vaddr_d    = itlb_req ? itlb_vaddr_i : dtlb_vaddr_i;
                    is_instr_d = itlb_req;
                    asid_d     = ASID_LEN'(asid_i);
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: state_d = (flush_i || any_hit) ? IDLE : WAIT_PTW;
            WAIT_PTW: begin
                if (flush_i) flushed_d = 1'b1;
                if (!ptw_active_i && !ptw_update_i.valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fill path; an sfence in the same cycle leaves the new entry invalid.
    always_comb begin
        entries_d = entries_q;
        repl_d    = repl_q;
        if (ptw_wr) begin
            entries_d[wr_idx].valid   = 1'b1;
            entries_d[wr_idx].is_1G   = ptw_update_i.is_1G;
            entries_d[wr_idx].is_2M   = ptw_update_i.is_2M;
            entries_d[wr_idx].vpn     = ptw_update_i.vpn;
            entries_d[wr_idx].asid    = ptw_update_i.asid;
            entries_d[wr_idx].content = ptw_update_i.content;
            repl_d = (repl_q == IDX_W'(SHARED_TLB_DEPTH - 1)) ? '0 : repl_q + 1'b1;
        end
        if (flush_tlb_i) begin
            for (int i = 0; i < SHARED_TLB_DEPTH; i++) entries_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        lookup_upd         = '0;
        lookup_upd.valid   = 1'b1;
        lookup_upd.is_1G   = entries_q[hit_idx].is_1G;
        lookup_upd.is_2M   = entries_q[hit_idx].is_2M;
        lookup_upd.vpn     = entries_q[hit_idx].vpn;
        lookup_upd.asid    = entries_q[hit_idx].asid;
        lookup_upd.content = entries_q[hit_idx].content;
    end

    always_comb begin
        upd                 = '0;
        itlb_miss_o         = (state_q == IDLE) && itlb_req;
        dtlb_miss_o         = (state_q == IDLE) && !itlb_req && dtlb_req;
        shared_tlb_access_o = 1'b0;
        shared_tlb_hit_o    = 1'b0;
        shared_tlb_vaddr_o  = '0;
        itlb_req_o          = 1'b0;
        if (state_q == LOOKUP && !flush_i) begin
            shared_tlb_access_o = 1'b1;
            shared_tlb_hit_o    = any_hit;
            shared_tlb_vaddr_o  = vaddr_q;
            itlb_req_o          = is_instr_q;
            if (any_hit) upd = lookup_upd;
        end
        if (ptw_wr && !flush_i && !flushed_q) begin
            upd       = ptw_update_i;
            upd.valid = 1'b1;
        end
        itlb_update_o = is_instr_q ? upd : '0;
        dtlb_update_o = is_instr_q ? '0 : upd;
    end

endmodule
